alu_jdl25175: RTL and testbench
===============================

// Module: alu_jdl25175
// PURPOSE
//  8-bit ALU with 16-bit registered result; datapath leaf driven by a controller that sets opcode/operands.
//  Opcodes 0-11 are single-cycle ops (no handshake); opcode 12 is a multi-cycle range sum started by 'calculate'.
//  opComplete flags a valid result on coreOut.
// PARAMETERS
//  none (widths fixed: operands 8 bit, result 16 bit, opcode 4 bit)
// PORTS
//  pulse      in   1   clock, rising-edge active
//  reset      in   1   reset, asynchronous, active-high
//  calculate  in   1   level start/hold for opcode 12; ignored for opcodes 0-11
//  opcode     in   4   operation select
//  opA        in   8   operand A, unsigned
//  opB        in   8   operand B, unsigned
//  coreOut    out  16  registered result
//  opComplete out  1   registered result-valid flag
// BEHAVIOUR
//  Reset: coreOut=16'h0000, opComplete=0, FSM=IDLE; takes effect immediately, aborts any opcode-12 run.
//  Opcodes 0-11: result computed from current inputs, registered on next rising edge (latency 1); opComplete=1 that cycle.
//   0 ADD  {8'b0,A}+{8'b0,B} (carry kept, max 510)
//   1 SUB  A-B as 16-bit two's complement
//   2 MUL  A*B unsigned, full 16 bits
//   3 CMP  coreOut = {13'b0, A>B, A==B, A<B}
//   4 AND  {8'b0, A&B}   5 OR {8'b0, A|B}   6 XOR {8'b0, A^B}   7 NOT {8'b0, ~A} (B ignored)
//   8 SHL  {8'b0,A} << B[2:0], 16-bit, no truncation
//   9 SHR  {8'b0, A >> B[2:0]} logical
//  10 ROL  {8'b0, A rotated left B[2:0]}   11 ROR {8'b0, A rotated right B[2:0]}
//  13-15: coreOut=0, opComplete=0.
//  Opcode 12 RANGE SUM, FSM IDLE/RUN/DONE:
//   IDLE, opcode==12, calculate=0: coreOut=0, opComplete=0.
//   IDLE, opcode==12, calculate=1 (start edge): latch A,B; acc<=A, idx<=A+1, opComplete<=0.
//     A==B -> DONE with coreOut<=A; A>B -> DONE with coreOut<=0; else -> RUN.
//   RUN: each edge acc<=acc+idx; when idx==latched B -> DONE, coreOut<=sum, opComplete<=1; else idx<=idx+1.
//     Latency start edge to opComplete = (B-A) cycles (min 1). Max sum 0..255 = 32640 fits 16 bits.
//   RUN/DONE: opcode/operand changes ignored (operands latched).
//   DONE: hold coreOut and opComplete=1 while calculate=1; calculate=0 -> IDLE, coreOut=0, opComplete=0.
//   calculate=0 during RUN: abort -> IDLE, coreOut=0, opComplete=0.
//   Leaving opcode 12 in IDLE resumes normal single-cycle ops next edge.
// TESTING
//  op0 A=127 B=126 -> next edge coreOut=253 (16'h00FD), opComplete=1; op1 same -> 1; op2 same -> 16002 (16'h3E82).
//  op3 A=126 B=127 -> 16'h0001; op4 AF&55 -> 0005; op5 F0|0F -> 00FF; op6 F6^6F -> 0099; op7 AA -> 0055.
//  op8 F0,3 -> 0780; op9 0F,3 -> 0001; op10 F0,3 -> 0087; op11 0F,3 -> 00E1.
//  op12 A=5 B=10, calculate 0 -> coreOut=0, opComplete=0; raise calculate -> 5 edges after start coreOut=45, opComplete=1, held.
//  op12 A=B=7 -> DONE after start edge, coreOut=7; A=9 B=3 -> coreOut=0, opComplete=1.
//  Reset asserted mid-RUN -> coreOut=0, opComplete=0 immediately; drop calculate mid-RUN -> IDLE, outputs 0.

Source files
------------

// File: rtl/alu_jdl25175_if.sv
// Controller-to-ALU bus: operation select, operands, start/hold level, and the registered result.
interface alu_jdl25175_if;
  logic        calculate;
  logic [3:0]  opcode;
  logic [7:0]  opA;
  logic [7:0]  opB;
  logic [15:0] coreOut;
  logic        opComplete;

  modport master (
    output calculate, opcode, opA, opB,
    input  coreOut, opComplete
  );

  modport slave (
    input  calculate, opcode, opA, opB,
    output coreOut, opComplete
  );
endinterface

// File: rtl/alu_jdl25175.sv
// 8-bit ALU with a registered 16-bit result.
// Opcodes 0-11 complete in one cycle. Opcode 12 is a multi-cycle range sum A+(A+1)+...+B.
module alu_jdl25175 (
  input  logic           pulse,
  input  logic           reset,
  alu_jdl25175_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] OP_RSUM = 4'd12;

  state_t      state, state_nx;
  logic [7:0]  b_q, b_nx;
  logic [7:0]  idx_q, idx_nx;
  logic [15:0] acc_q, acc_nx;
  logic [15:0] out_q, out_nx;
  logic        vld_q, vld_nx;

  logic [15:0] op_res;
  logic        op_vld;
  logic [2:0]  sh;
  logic [15:0] ext_a, ext_b, dbl_a, rot_l, rot_r;
  logic [15:0] sum_nx;

  assign sh    = bus.opB[2:0];
  assign ext_a = {8'b0, bus.opA};
  assign ext_b = {8'b0, bus.opB};
  // Rotating a doubled copy of A leaves the rotated byte in one half.
  assign dbl_a = {bus.opA, bus.opA};
  assign rot_l = dbl_a << sh;
  assign rot_r = dbl_a >> sh;
  assign sum_nx = acc_q + {8'b0, idx_q};

  // Single-cycle operation result from the current inputs
  always_comb begin
    op_res = '0;
    op_vld = 1'b1;
    case (bus.opcode)
      4'd0:    op_res = ext_a + ext_b;
      4'd1:    op_res = ext_a - ext_b;
      4'd2:    op_res = ext_a * ext_b;
      4'd3:    op_res = {13'b0, bus.opA > bus.opB, bus.opA == bus.opB, bus.opA < bus.opB};
      4'd4:    op_res = {8'b0, bus.opA & bus.opB};
      4'd5:    op_res = {8'b0, bus.opA | bus.opB};
      4'd6:    op_res = {8'b0, bus.opA ^ bus.opB};
      4'd7:    op_res = {8'b0, ~bus.opA};
      4'd8:    op_res = ext_a << sh;
      4'd9:    op_res = {8'b0, bus.opA >> sh};
      4'd10:   op_res = {8'b0, rot_l[15:8]};
      4'd11:   op_res = {8'b0, rot_r[7:0]};
      default: op_vld = 1'b0;
    endcase
  end

  // Next-state, range-sum datapath and next registered outputs
  always_comb begin
    state_nx = state;
    b_nx     = b_q;
    idx_nx   = idx_q;
    acc_nx   = acc_q;
    out_nx   = out_q;
    vld_nx   = vld_q;
    case (state)
      IDLE: begin
        if (bus.opcode == OP_RSUM) begin
          out_nx = '0;
          vld_nx = 1'b0;
          if (bus.calculate) begin
            b_nx   = bus.opB;
            acc_nx = ext_a;
            idx_nx = bus.opA + 8'd1;
            if (bus.opA == bus.opB) begin
              state_nx = DONE;
              out_nx   = ext_a;
              vld_nx   = 1'b1;
            end else if (bus.opA > bus.opB) begin
              state_nx = DONE;
              vld_nx   = 1'b1;
            end else begin
              state_nx = RUN;
            end
          end
        end else begin
          out_nx = op_res;
          vld_nx = op_vld;
        end
      end
      RUN: begin
        if (!bus.calculate) begin
          state_nx = IDLE;
          out_nx   = '0;
          vld_nx   = 1'b0;
        end else begin
          acc_nx = sum_nx;
          if (idx_q == b_q) begin
            state_nx = DONE;
            out_nx   = sum_nx;
            vld_nx   = 1'b1;
          end else begin
            idx_nx = idx_q + 8'd1;
          end
        end
      end
      DONE: begin
        if (!bus.calculate) begin
          state_nx = IDLE;
          out_nx   = '0;
          vld_nx   = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        out_nx   = '0;
        vld_nx   = 1'b0;
      end
    endcase
  end

  // State and result registers, cleared immediately by reset
  always_ff @(posedge pulse or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      b_q   <= '0;
      idx_q <= '0;
      acc_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state <= state_nx;
      b_q   <= b_nx;
      idx_q <= idx_nx;
      acc_q <= acc_nx;
      out_q <= out_nx;
      vld_q <= vld_nx;
    end
  end

  assign bus.coreOut    = out_q;
  assign bus.opComplete = vld_q;

endmodule

// File: tb/tb_alu_jdl25175.sv
// Bench for alu_jdl25175: directed vectors with literal expectations plus a
// cycle-by-cycle behavioural model checked on every falling edge.
module tb_alu_jdl25175;

  logic pulse = 1'b0;
  logic reset;

  alu_jdl25175_if bus_if ();

  alu_jdl25175 dut (
    .pulse (pulse),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 pulse = ~pulse;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: 0 idle, 1 summing (countdown of edges left), 2 holding result
  int          m_st = 0;
  int          m_left = 0;
  int          m_sum = 0;
  logic [15:0] exp_out = '0;
  logic        exp_vld = 1'b0;

  function automatic logic [15:0] op_result(int op, int a, int b);
    int r;
    int s;
    s = b % 8;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a * b;
      3:  r = (a > b ? 4 : 0) + (a == b ? 2 : 0) + (a < b ? 1 : 0);
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = 255 - a;
      8:  r = a * (2 ** s);
      9:  r = a / (2 ** s);
      10: r = ((a * (2 ** s)) % 256) + a / (2 ** (8 - s));
      11: r = a / (2 ** s) + ((a * (2 ** (8 - s))) % 256);
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  always @(posedge pulse or posedge reset) begin
    int a, b, op;
    a  = int'(bus_if.opA);
    b  = int'(bus_if.opB);
    op = int'(bus_if.opcode);
    if (reset) begin
      m_st = 0; exp_out = '0; exp_vld = 1'b0;
    end else begin
      case (m_st)
        0: begin
          if (op == 12) begin
            exp_out = '0; exp_vld = 1'b0;
            if (bus_if.calculate) begin
              if (a >= b) begin
                exp_out = (a == b) ? 16'(a) : 16'd0;
                exp_vld = 1'b1;
                m_st = 2;
              end else begin
                m_sum = 0;
                for (int k = a; k <= b; k++) m_sum += k;
                m_left = b - a;
                m_st = 1;
              end
            end
          end else begin
            exp_out = op_result(op, a, b);
            exp_vld = (op < 12);
          end
        end
        1: begin
          if (!bus_if.calculate) begin
            m_st = 0; exp_out = '0; exp_vld = 1'b0;
          end else begin
            m_left--;
            if (m_left == 0) begin
              exp_out = 16'(m_sum); exp_vld = 1'b1; m_st = 2;
            end
          end
        end
        default: begin
          if (!bus_if.calculate) begin
            m_st = 0; exp_out = '0; exp_vld = 1'b0;
          end
        end
      endcase
    end
  end

  always @(negedge pulse) begin
    if (cmp_en) begin
      tests++;
      if (bus_if.coreOut !== exp_out || bus_if.opComplete !== exp_vld) begin
        fails++;
        $display("FAIL model t=%0t got out=%h vld=%b want out=%h vld=%b",
                 $time, bus_if.coreOut, bus_if.opComplete, exp_out, exp_vld);
      end
    end
  end

  task automatic check(string name, logic [15:0] got, logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic drive(int op, int a, int b, bit c);
    bus_if.opcode    = 4'(op);
    bus_if.opA       = 8'(a);
    bus_if.opB       = 8'(b);
    bus_if.calculate = c;
  endtask

  task automatic step();
    @(negedge pulse);
  endtask

  task automatic check_both(string name, logic [15:0] out, logic vld);
    check({name, "_out"}, bus_if.coreOut, out);
    check({name, "_vld"}, {15'b0, bus_if.opComplete}, {15'b0, vld});
  endtask

  typedef struct {
    int          op;
    int          a;
    int          b;
    logic [15:0] want;
  } vec_t;

  vec_t vecs[16] = '{
    '{0, 127, 126, 16'h00FD}, '{1, 127, 126, 16'h0001}, '{2, 127, 126, 16'h3E82},
    '{3, 126, 127, 16'h0001}, '{4, 'hAF, 'h55, 16'h0005}, '{5, 'hF0, 'h0F, 16'h00FF},
    '{6, 'hF6, 'h6F, 16'h0099}, '{7, 'hAA, 0, 16'h0055},  '{8, 'hF0, 3, 16'h0780},
    '{9, 'h0F, 3, 16'h0001},  '{10, 'hF0, 3, 16'h0087},  '{11, 'h0F, 3, 16'h00E1},
    '{0, 255, 255, 16'h01FE}, '{1, 0, 1, 16'hFFFF},      '{2, 255, 255, 16'hFE01},
    '{13, 255, 255, 16'h0000}
  };

  initial begin
    int n;
    reset = 1'b1;
    drive(0, 0, 0, 1'b0);
    repeat (2) step();
    check_both("reset", 16'h0000, 1'b0);
    reset = 1'b0;
    cmp_en = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      step();
      check_both($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i].want, vecs[i].op < 12);
    end

    // Range sum 5..10 = 45, five edges after the start edge
    drive(12, 5, 10, 1'b0);
    step();
    check_both("rs_idle", 16'h0000, 1'b0);
    bus_if.calculate = 1'b1;
    step();
    bus_if.opA = 8'd200;
    repeat (4) begin
      step();
      check("rs_busy_vld", {15'b0, bus_if.opComplete}, 16'h0000);
    end
    step();
    check_both("rs_5_10", 16'd45, 1'b1);
    drive(0, 1, 126, 1'b1);
    repeat (2) begin
      step();
      check_both("rs_hold", 16'd45, 1'b1);
    end
    bus_if.calculate = 1'b0;
    step();
    check_both("rs_release", 16'h0000, 1'b0);
    step();
    check_both("resume_add", 16'd127, 1'b1);

    drive(12, 7, 7, 1'b1);
    step();
    check_both("rs_equal", 16'd7, 1'b1);
    step();
    check_both("rs_equal_hold", 16'd7, 1'b1);
    bus_if.calculate = 1'b0;
    step();

    drive(12, 9, 3, 1'b1);
    step();
    check_both("rs_a_gt_b", 16'h0000, 1'b1);
    bus_if.calculate = 1'b0;
    step();

    // Full range 0..255, bounded wait
    drive(12, 0, 255, 1'b1);
    step();
    n = 0;
    while (!bus_if.opComplete && n < 300) begin
      step();
      n++;
    end
    check("rs_full_latency", 16'(n), 16'd255);
    check_both("rs_full", 16'd32640, 1'b1);
    bus_if.calculate = 1'b0;
    step();

    // Abort mid-run, then restart 3..4 = 7
    drive(12, 0, 255, 1'b1);
    repeat (3) step();
    bus_if.calculate = 1'b0;
    step();
    check_both("rs_abort", 16'h0000, 1'b0);
    drive(12, 3, 4, 1'b1);
    step();
    step();
    check_both("rs_restart", 16'd7, 1'b1);
    bus_if.calculate = 1'b0;
    step();

    // Asynchronous reset while a result is showing, and mid-run
    drive(0, 127, 126, 1'b0);
    step();
    check_both("pre_reset", 16'h00FD, 1'b1);
    #2 reset = 1'b1;
    #1 check_both("async_reset_op", 16'h0000, 1'b0);
    step();
    drive(12, 0, 255, 1'b1);
    reset = 1'b0;
    repeat (3) step();
    #2 reset = 1'b1;
    #1 check_both("async_reset_run", 16'h0000, 1'b0);
    bus_if.calculate = 1'b0;
    step();
    reset = 1'b0;
    drive(6, 'hF6, 'h6F, 1'b0);
    step();
    check_both("post_reset", 16'h0099, 1'b1);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
